// File: rtl/multi_lbuff_pkg.sv
// Shared types and helpers for the multi line-buffer fill stage.
// Fill FSM states, width helpers and a lowest-set-bit picker.
package multi_lbuff_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_RSP,
    WRITE,
    DONE
  } fill_state_t;

  localparam int MAX_BUFFS = 8;

  function automatic int calc_tile_per_line(input int width_px, input int tile_width);
    return width_px / tile_width;
  endfunction

  // Counter/address width for a range of 'depth' values, never below 1 bit.
  function automatic int calc_addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic logic [2:0] lowest_set_bit(input logic [MAX_BUFFS-1:0] vec);
    logic [2:0] idx;
    idx = '0;
    for (int i = MAX_BUFFS - 1; i >= 0; i--) begin
      if (vec[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/multi_line_buffers_arbiter.sv
// Round-robin fill arbiter: searches from the pointer, skipping masked
// (displayed) buffers; the pointer moves past a buffer once its fill is done.
module lbuff_rr_arbiter
  import multi_lbuff_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = calc_addr_width(N)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [N-1:0]  req_i,
  input  logic [N-1:0]  mask_i,
  input  logic          adv_i,
  input  logic [IW-1:0] adv_idx_i,
  output logic          gnt_vld_o,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          skip_o
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  elig;
  int            idx;

  assign elig   = req_i & ~mask_i;
  assign skip_o = |(req_i & mask_i);

  // Descending scan so the candidate nearest the pointer is the one kept.
  always_comb begin
    gnt_vld_o = 1'b0;
    gnt_idx_o = '0;
    gnt_o     = '0;
    idx       = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % N;
      if (elig[idx]) begin
        gnt_vld_o = 1'b1;
        gnt_idx_o = IW'(idx);
      end
    end
    if (gnt_vld_o) gnt_o[gnt_idx_o] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (adv_i) ptr_d = (adv_idx_i == IW'(N - 1)) ? '0 : adv_idx_i + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/xilinx_single_port_ram.sv
// Single-port block RAM, read-first, one cycle read latency.
module xilinx_single_port_ram #(
  parameter int RAM_WIDTH  = 12,
  parameter int RAM_DEPTH  = 160,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clka,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [RAM_WIDTH-1:0]  dina,
  input  logic                  wea,
  input  logic                  ena,
  output logic [RAM_WIDTH-1:0]  douta
);

  logic [RAM_WIDTH-1:0] mem_q [RAM_DEPTH];

  always_ff @(posedge clka) begin
    if (ena) begin
      if (wea) mem_q[addra] <= dina;
      douta <= mem_q[addra];
    end
  end

endmodule

// File: rtl/multi_line_buffers.sv
// NUM_BUFFS line buffers filled one at a time from frame-buffer words while
// the display path reads the selected buffer with one cycle of latency.
module multi_line_buffers
  import multi_lbuff_pkg::*;
#(
  parameter int COLR_PXL_WIDTH   = 12,
  parameter int TILE_WIDTH       = 4,
  parameter int WIDTH_PX         = 640,
  parameter int NUM_BUFFS        = 2,
  parameter int TILES_PER_ROW    = 5,
  parameter int FBUFF_DEPTH      = 4800,
  parameter int FBUFF_ADDR_WIDTH = 13,
  parameter int FBUFF_DATA_WIDTH = 60,
  parameter int RSP_TIMEOUT      = 255,
  parameter int TILE_PER_LINE    = calc_tile_per_line(WIDTH_PX, TILE_WIDTH),
  parameter int LBUFF_ADDR_WIDTH = calc_addr_width(TILE_PER_LINE)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_BUFFS-1:0]        buff_fill_req_i,
  input  logic [NUM_BUFFS-1:0]        buff_sel_i,
  input  logic                        frame_start_i,
  input  logic [LBUFF_ADDR_WIDTH-1:0] disp_pxl_id_i,
  input  logic [FBUFF_DATA_WIDTH-1:0] fbuff_data_i,
  input  logic                        fbuff_rd_rsp_i,
  output logic [NUM_BUFFS-1:0]        buff_fill_done_o,
  output logic [COLR_PXL_WIDTH-1:0]   disp_pxl_o,
  output logic                        fbuff_rd_req_o,
  output logic [FBUFF_ADDR_WIDTH-1:0] fbuff_addr_o,
  output logic                        fill_busy_o,
  output logic                        fill_err_o
);

  localparam int IW  = calc_addr_width(NUM_BUFFS);
  localparam int TCW = calc_addr_width(TILES_PER_ROW);
  localparam int TMW = calc_addr_width(RSP_TIMEOUT + 1);
  localparam int LAW = LBUFF_ADDR_WIDTH;
  localparam int FAW = FBUFF_ADDR_WIDTH;
  localparam int CW  = COLR_PXL_WIDTH;

  fill_state_t           state_q, state_d;
  logic [IW-1:0]         fill_idx_q, fill_idx_d;
  logic [NUM_BUFFS-1:0]  fill_oh_q, fill_oh_d;
  logic [LAW-1:0]        wr_addr_q, wr_addr_d;
  logic [TCW-1:0]        tile_cnt_q, tile_cnt_d;
  logic [FBUFF_DATA_WIDTH-1:0] data_q, data_d;
  logic [FAW-1:0]        fbuff_addr_q, fbuff_addr_d;
  logic [TMW-1:0]        tmo_q, tmo_d;
  logic                  pend_q, pend_d;
  logic                  err_q, err_d;
  logic                  skip_q, clash_q, skip_now, clash_now;
  logic [IW-1:0]         sel_idx_q;
  logic                  sel_any_q;

  logic                  arb_vld, arb_skip, arb_adv;
  logic [NUM_BUFFS-1:0]  arb_gnt;
  logic [IW-1:0]         arb_idx;
  logic                  line_end;
  logic [CW-1:0]         tile_w [TILES_PER_ROW];
  logic [CW-1:0]         rd_data [NUM_BUFFS];

  lbuff_rr_arbiter #(.N(NUM_BUFFS), .IW(IW)) u_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (buff_fill_req_i),
    .mask_i    (buff_sel_i),
    .adv_i     (arb_adv),
    .adv_idx_i (fill_idx_q),
    .gnt_vld_o (arb_vld),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx),
    .skip_o    (arb_skip)
  );

  for (genvar g = 0; g < TILES_PER_ROW; g++) begin : g_tile
    assign tile_w[g] = data_q[g*CW +: CW];
  end

  assign line_end  = (wr_addr_q == LAW'(TILE_PER_LINE - 1));
  // Errors fire once on the rising edge of a skip or display/fill clash.
  assign skip_now  = (state_q == IDLE) && arb_skip;
  assign clash_now = (state_q != IDLE) && buff_sel_i[fill_idx_q];

  always_comb begin
    state_d      = state_q;
    fill_idx_d   = fill_idx_q;
    fill_oh_d    = fill_oh_q;
    wr_addr_d    = wr_addr_q;
    tile_cnt_d   = tile_cnt_q;
    data_d       = data_q;
    fbuff_addr_d = fbuff_addr_q;
    tmo_d        = tmo_q;
    pend_d       = pend_q;
    arb_adv      = 1'b0;
    err_d        = (skip_now && !skip_q) || (clash_now && !clash_q);
    if (frame_start_i && (state_q != IDLE)) pend_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (frame_start_i) fbuff_addr_d = '0;
        if (arb_vld) begin
          fill_idx_d = arb_idx;
          fill_oh_d  = arb_gnt;
          wr_addr_d  = '0;
          state_d    = REQ;
        end
      end
      REQ: begin
        tile_cnt_d = '0;
        tmo_d      = TMW'(RSP_TIMEOUT);
        state_d    = WAIT_RSP;
      end
      WAIT_RSP: begin
        if (fbuff_rd_rsp_i) begin
          data_d       = fbuff_data_i;
          fbuff_addr_d = (fbuff_addr_q == FAW'(FBUFF_DEPTH - 1)) ? '0 : fbuff_addr_q + 1'b1;
          state_d      = WRITE;
        end else if (RSP_TIMEOUT != 0) begin
          if (tmo_q == TMW'(1)) begin
            err_d   = 1'b1;
            state_d = REQ;
          end else begin
            tmo_d = tmo_q - 1'b1;
          end
        end
      end
      WRITE: begin
        wr_addr_d = line_end ? '0 : wr_addr_q + 1'b1;
        if (line_end) state_d = DONE;
        else if (tile_cnt_q == TCW'(TILES_PER_ROW - 1)) state_d = REQ;
        else tile_cnt_d = tile_cnt_q + 1'b1;
      end
      DONE: begin
        arb_adv = 1'b1;
        state_d = IDLE;
        if (pend_q || frame_start_i) begin
          fbuff_addr_d = '0;
          pend_d       = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      fill_idx_q   <= '0;
      fill_oh_q    <= '0;
      wr_addr_q    <= '0;
      tile_cnt_q   <= '0;
      data_q       <= '0;
      fbuff_addr_q <= '0;
      tmo_q        <= '0;
      pend_q       <= 1'b0;
      err_q        <= 1'b0;
      skip_q       <= 1'b0;
      clash_q      <= 1'b0;
      sel_idx_q    <= '0;
      sel_any_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      fill_idx_q   <= fill_idx_d;
      fill_oh_q    <= fill_oh_d;
      wr_addr_q    <= wr_addr_d;
      tile_cnt_q   <= tile_cnt_d;
      data_q       <= data_d;
      fbuff_addr_q <= fbuff_addr_d;
      tmo_q        <= tmo_d;
      pend_q       <= pend_d;
      err_q        <= err_d;
      skip_q       <= skip_now;
      clash_q      <= clash_now;
      sel_idx_q    <= IW'(lowest_set_bit(MAX_BUFFS'(buff_sel_i)));
      sel_any_q    <= |buff_sel_i;
    end
  end

  // The buffer under fill is addressed by the write pointer; others by the display.
  for (genvar g = 0; g < NUM_BUFFS; g++) begin : g_buf
    logic           use_wr;
    logic [LAW-1:0] ram_addr;
    assign use_wr   = (state_q != IDLE) && (fill_idx_q == IW'(g));
    assign ram_addr = use_wr ? wr_addr_q : disp_pxl_id_i;
    xilinx_single_port_ram #(
      .RAM_WIDTH  (CW),
      .RAM_DEPTH  (TILE_PER_LINE),
      .ADDR_WIDTH (LAW)
    ) u_ram (
      .clka  (clk_i),
      .addra (ram_addr),
      .dina  (tile_w[tile_cnt_q]),
      .wea   (use_wr && (state_q == WRITE)),
      .ena   (1'b1),
      .douta (rd_data[g])
    );
  end

  assign disp_pxl_o       = sel_any_q ? rd_data[sel_idx_q] : '0;
  assign fbuff_rd_req_o   = (state_q == REQ);
  assign buff_fill_done_o = (state_q == DONE) ? fill_oh_q : '0;
  assign fbuff_addr_o     = fbuff_addr_q;
  assign fill_busy_o      = (state_q != IDLE);
  assign fill_err_o       = err_q;

endmodule
